// File: rtl/elastic_pipe_reg_pkg.sv
// elastic_pipe_reg_pkg: shared handshake types and sizing helpers for elastic pipeline stages.
package elastic_pipe_reg_pkg;
   localparam int HS_WIDTH = 64;
   typedef struct packed {
      logic                valid;
      logic [HS_WIDTH-1:0] data;
   } hs_t;
   function automatic int occ_w(input int depth);
      return $clog2(2 * depth + 1);
   endfunction
endpackage

// File: rtl/elastic_pipe_reg_stage.sv
// elastic_stage: one elastic stage (main register plus skid register) with registered up_ready.
module elastic_stage #(
   parameter int WIDTH = 64
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             flush,
   input  logic             up_valid,
   output logic             up_ready,
   input  logic [WIDTH-1:0] up_data,
   output logic             dn_valid,
   input  logic             dn_ready,
   output logic [WIDTH-1:0] dn_data,
   output logic             main_v,
   output logic             skid_v
);
   logic             m_v_q, m_v_d, s_v_q, s_v_d;
   logic [WIDTH-1:0] m_data_q, m_data_d, s_data_q, s_data_d;
   logic             pop, push;
   assign up_ready = ~s_v_q;
   assign dn_valid = m_v_q;
   assign dn_data  = m_data_q;
   assign main_v   = m_v_q;
   assign skid_v   = s_v_q;
   always_comb begin
      pop      = m_v_q & dn_ready;
      push     = up_valid & ~s_v_q;
      m_v_d    = m_v_q;
      s_v_d    = s_v_q;
      m_data_d = m_data_q;
      s_data_d = s_data_q;
      if (flush) begin
         m_v_d = 1'b0;
         s_v_d = 1'b0;
      end else if (s_v_q) begin
         // skid occupied: upstream is stalled, so only a pop can move data
         if (pop) begin
            m_data_d = s_data_q;
            s_v_d    = 1'b0;
         end
      end else if (push && (!m_v_q || pop)) begin
         m_data_d = up_data;
         m_v_d    = 1'b1;
      end else if (push) begin
         s_data_d = up_data;
         s_v_d    = 1'b1;
      end else if (pop) begin
         m_v_d = 1'b0;
      end
   end
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         m_v_q    <= 1'b0;
         s_v_q    <= 1'b0;
         m_data_q <= '0;
         s_data_q <= '0;
      end else begin
         m_v_q    <= m_v_d;
         s_v_q    <= s_v_d;
         m_data_q <= m_data_d;
         s_data_q <= s_data_d;
      end
   end
endmodule

// File: rtl/elastic_pipe_reg.sv
// elastic_pipe_reg: DEPTH chained elastic stages with flush and flop-derived occupancy.
module elastic_pipe_reg
   import elastic_pipe_reg_pkg::*;
#(
   parameter int WIDTH = 64,
   parameter int DEPTH = 2
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      flush,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic [WIDTH-1:0]          in_data,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [WIDTH-1:0]          out_data,
   output logic [occ_w(DEPTH)-1:0]   occupancy
);
   localparam int OW = occ_w(DEPTH);
   logic [DEPTH:0]   vld, rdy;
   logic [WIDTH-1:0] dat [DEPTH+1];
   logic [DEPTH-1:0] main_v, skid_v;
   assign vld[0]     = in_valid;
   assign dat[0]     = in_data;
   assign rdy[DEPTH] = out_ready;
   assign in_ready   = rdy[0];
   assign out_valid  = vld[DEPTH];
   assign out_data   = dat[DEPTH];
   for (genvar i = 0; i < DEPTH; i++) begin : g_stage
      elastic_stage #(.WIDTH(WIDTH)) u_stage (
         .clk     (clk),
         .reset   (reset),
         .flush   (flush),
         .up_valid(vld[i]),
         .up_ready(rdy[i]),
         .up_data (dat[i]),
         .dn_valid(vld[i+1]),
         .dn_ready(rdy[i+1]),
         .dn_data (dat[i+1]),
         .main_v  (main_v[i]),
         .skid_v  (skid_v[i])
      );
   end
   always_comb begin
      occupancy = '0;
      for (int i = 0; i < DEPTH; i++)
         occupancy = occupancy + OW'(main_v[i]) + OW'(skid_v[i]);
   end
endmodule

// File: tb/tb_elastic_pipe_reg.sv
// tb_elastic_pipe_reg: directed vector table on DEPTH=2 plus random scoreboard runs on DEPTH=1/2/3.
module tb_elastic_pipe_reg;
   import elastic_pipe_reg_pkg::*;
   logic        clk = 0, reset = 0, flush = 0, in_valid = 0, out_ready = 0;
   logic [15:0] in_data = '0;
   logic        ir1, ir2, ir3, ov1, ov2, ov3;
   logic [15:0] od1, od2, od3;
   logic [occ_w(1)-1:0] occ1;
   logic [occ_w(2)-1:0] occ2;
   logic [occ_w(3)-1:0] occ3;
   int total = 0, bad = 0;

   always #5 clk = ~clk;

   elastic_pipe_reg #(.WIDTH(16), .DEPTH(2)) dut (
      .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(ir2),
      .in_data(in_data), .out_valid(ov2), .out_ready(out_ready), .out_data(od2), .occupancy(occ2));
   elastic_pipe_reg #(.WIDTH(16), .DEPTH(1)) dut1 (
      .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(ir1),
      .in_data(in_data), .out_valid(ov1), .out_ready(out_ready), .out_data(od1), .occupancy(occ1));
   elastic_pipe_reg #(.WIDTH(16), .DEPTH(3)) dut3 (
      .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(ir3),
      .in_data(in_data), .out_valid(ov3), .out_ready(out_ready), .out_data(od3), .occupancy(occ3));

   logic [2:0]  ir_v, ov_v;
   logic [15:0] od_a [3];
   int          occ_a [3];
   assign ir_v = {ir3, ir2, ir1};
   assign ov_v = {ov3, ov2, ov1};
   assign od_a[0] = od1;
   assign od_a[1] = od2;
   assign od_a[2] = od3;
   assign occ_a[0] = int'(occ1);
   assign occ_a[1] = int'(occ2);
   assign occ_a[2] = int'(occ3);

   typedef struct {
      logic        fl, iv;
      logic [15:0] id;
      logic        ordy, ir, ov;
      logic [15:0] od;
      int          occ;
   } vec_t;
   vec_t vecs [$];
   logic [15:0] sb [3][$];

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s got=%0h want=%0h", nm, act, exp);
      end
   endtask

   task automatic add(input logic fl, iv, input logic [15:0] id, input logic ordy, ir, ov,
                      input logic [15:0] od, input int occ);
      vec_t v;
      v.fl = fl; v.iv = iv; v.id = id; v.ordy = ordy; v.ir = ir; v.ov = ov; v.od = od; v.occ = occ;
      vecs.push_back(v);
   endtask

   task automatic chk_idle(input string nm);
      chk({nm, ".ir"}, 64'(ir2), 64'd1);
      chk({nm, ".ov"}, 64'(ov2), 64'd0);
      chk({nm, ".od"}, 64'(od2), 64'd0);
      chk({nm, ".occ"}, 64'(occ2), 64'd0);
   endtask

   initial begin
      // back-to-back stream with out_ready=1
      for (int k = 1; k <= 8; k++) add(0, 1, 16'(k), 1, 1, k > 1, 16'(k - 1), k == 1 ? 1 : 2);
      add(0, 0, 0, 1, 1, 1, 16'h08, 1);
      add(0, 0, 0, 1, 1, 0, 0, 0);
      // fill to capacity with out_ready=0, then drain
      add(0, 1, 16'h11, 0, 1, 0, 0, 1);
      add(0, 1, 16'h12, 0, 1, 1, 16'h11, 2);
      add(0, 1, 16'h13, 0, 1, 1, 16'h11, 3);
      add(0, 1, 16'h14, 0, 0, 1, 16'h11, 4);
      add(0, 1, 16'h15, 0, 0, 1, 16'h11, 4);
      add(0, 0, 0, 1, 0, 1, 16'h12, 3);
      add(0, 0, 0, 1, 1, 1, 16'h13, 2);
      add(0, 0, 0, 1, 1, 1, 16'h14, 1);
      add(0, 0, 0, 1, 1, 0, 0, 0);
      // full, then out_ready and in_valid held high
      add(0, 1, 16'h21, 0, 1, 0, 0, 1);
      add(0, 1, 16'h22, 0, 1, 1, 16'h21, 2);
      add(0, 1, 16'h23, 0, 1, 1, 16'h21, 3);
      add(0, 1, 16'h24, 0, 0, 1, 16'h21, 4);
      add(0, 1, 16'h25, 1, 0, 1, 16'h22, 3);
      add(0, 1, 16'h25, 1, 1, 1, 16'h23, 2);
      add(0, 1, 16'h25, 1, 1, 1, 16'h24, 2);
      add(0, 1, 16'h26, 1, 1, 1, 16'h25, 2);
      add(0, 1, 16'h27, 1, 1, 1, 16'h26, 2);
      add(0, 0, 0, 1, 1, 1, 16'h27, 1);
      add(0, 0, 0, 1, 1, 0, 0, 0);
      // occupancy 3 then flush with a live handshake on both ports
      add(0, 1, 16'h31, 0, 1, 0, 0, 1);
      add(0, 1, 16'h32, 0, 1, 1, 16'h31, 2);
      add(0, 1, 16'h33, 0, 1, 1, 16'h31, 3);
      add(1, 1, 16'h34, 1, 1, 0, 0, 0);
      add(0, 1, 16'h35, 1, 1, 0, 0, 1);
      add(0, 0, 0, 1, 1, 1, 16'h35, 1);
      add(0, 0, 0, 1, 1, 0, 0, 0);

      #1 chk_idle("reset");
      @(negedge clk) reset = 1;
      @(posedge clk) #1;

      foreach (vecs[i]) begin
         flush = vecs[i].fl; in_valid = vecs[i].iv; in_data = vecs[i].id; out_ready = vecs[i].ordy;
         @(posedge clk) #1;
         chk($sformatf("row%0d.ir", i), 64'(ir2), 64'(vecs[i].ir));
         chk($sformatf("row%0d.ov", i), 64'(ov2), 64'(vecs[i].ov));
         chk($sformatf("row%0d.occ", i), 64'(occ2), 64'(vecs[i].occ));
         if (vecs[i].ov) chk($sformatf("row%0d.od", i), 64'(od2), 64'(vecs[i].od));
      end

      // async reset mid-stream, held two cycles
      flush = 0; in_valid = 1; in_data = 16'h41; out_ready = 0;
      @(posedge clk) #1 in_data = 16'h42;
      @(posedge clk) #1;
      chk("pre_reset.occ", 64'(occ2), 64'd2);
      @(negedge clk) reset = 0;
      #1 chk_idle("async_reset");
      repeat (2) @(posedge clk);
      #1 chk_idle("held_reset");
      @(negedge clk) begin reset = 1; in_valid = 0; end
      @(posedge clk) #1;

      for (int c = 0; c < 10000; c++) begin
         logic [2:0] acc;
         in_valid = 1'($urandom_range(0, 1));
         in_data = 16'($urandom);
         out_ready = 1'($urandom_range(0, 1));
         #1;
         for (int k = 0; k < 3; k++) begin
            acc[k] = in_valid & ir_v[k];
            if (ov_v[k] && out_ready) begin
               if (sb[k].size() == 0) begin
                  total++;
                  bad++;
                  $display("FAIL rnd%0d.underflow cycle=%0d got=%0h want=none", k, c, od_a[k]);
               end else chk($sformatf("rnd%0d.od c%0d", k, c), 64'(od_a[k]), 64'(sb[k].pop_front()));
            end
         end
         @(posedge clk) #1;
         for (int k = 0; k < 3; k++) begin
            if (acc[k]) sb[k].push_back(in_data);
            chk($sformatf("rnd%0d.occ c%0d", k, c), 64'(occ_a[k]), 64'(sb[k].size()));
         end
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
